// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg: shared constants for the DDR3 multi-port arbiter
package ddr3_arb_pkg;
    localparam int NUM_PORTS_DEFAULT = 4;
    localparam int PORT_ID_WIDTH = $clog2(NUM_PORTS_DEFAULT);
    localparam int ARB_RR = 0;
    localparam int ARB_FIXED = 1;
    localparam logic [6:0] AVL_SIZE_SINGLE = 7'd1;
endpackage

// File: rtl/ddr3_return_tag_fifo.sv
// ddr3_return_tag_fifo: in-order FIFO of issuing port IDs for outstanding reads
module ddr3_return_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    assign head = mem[rd_ptr];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/ddr3_port_arbiter.sv
// ddr3_port_arbiter: arbitrates NUM_PORTS Avalon masters onto one DDR3 controller port
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_DEPTH = 16,
    parameter int ARB_MODE = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic [NUM_PORTS-1:0]              port_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   port_wdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_be,
    input  logic [NUM_PORTS-1:0]              port_read_req,
    input  logic [NUM_PORTS-1:0]              port_write_req,
    output logic [DATA_WIDTH-1:0]             port_rdata,
    output logic [NUM_PORTS-1:0]              port_rdata_valid,
    input  logic                              avl_ready,
    output logic                              avl_burstbegin,
    output logic [ADDR_WIDTH-1:0]             avl_addr,
    output logic [DATA_WIDTH-1:0]             avl_wdata,
    output logic [DATA_WIDTH/8-1:0]           avl_be,
    output logic                              avl_read_req,
    output logic                              avl_write_req,
    output logic [6:0]                        avl_size,
    input  logic                              avl_rdata_valid,
    input  logic [DATA_WIDTH-1:0]             avl_rdata,
    output logic                              err_spurious_return
);
    localparam int ID_W = $clog2(NUM_PORTS);
    localparam int BE_W = DATA_WIDTH / 8;
    logic [ID_W-1:0] rr_ptr, grant, tag_head;
    logic [NUM_PORTS-1:0] eligible;
    logic any_eligible, accept, tag_full, tag_empty, pop;
    function automatic logic [ID_W-1:0] pick(input logic [NUM_PORTS-1:0] e, input logic [ID_W-1:0] p);
        logic [ID_W-1:0] r;
        logic found;
        int k;
        r = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = (int'(p) + i) % NUM_PORTS;
            if (!found && e[k]) begin
                r = ID_W'(k);
                found = 1'b1;
            end
        end
        return r;
    endfunction
    // A full tag FIFO blocks reads only; writes keep arbitrating.
    assign eligible = (port_read_req & {NUM_PORTS{!tag_full}}) | port_write_req;
    assign any_eligible = !reset && |eligible;
    assign grant = pick(eligible, ARB_MODE == ARB_FIXED ? '0 : rr_ptr);
    assign avl_addr = port_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
    assign avl_wdata = port_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
    assign avl_be = port_be[grant*BE_W +: BE_W];
    assign avl_read_req = any_eligible && port_read_req[grant];
    assign avl_write_req = any_eligible && port_write_req[grant];
    assign avl_burstbegin = avl_read_req | avl_write_req;
    assign avl_size = AVL_SIZE_SINGLE;
    assign accept = any_eligible && avl_ready;
    assign port_ready = accept ? NUM_PORTS'(1) << grant : '0;
    assign pop = avl_rdata_valid && !tag_empty;
    ddr3_return_tag_fifo #(.DEPTH(TAG_DEPTH), .WIDTH(ID_W)) u_tags (
        .clk(clk),
        .reset(reset),
        .push(accept && avl_read_req),
        .pop(pop),
        .din(grant),
        .head(tag_head),
        .full(tag_full),
        .empty(tag_empty)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            port_rdata <= '0;
            port_rdata_valid <= '0;
            err_spurious_return <= 1'b0;
        end else begin
            if (accept) rr_ptr <= grant == ID_W'(NUM_PORTS - 1) ? '0 : grant + 1'b1;
            if (pop) port_rdata <= avl_rdata;
            port_rdata_valid <= pop ? NUM_PORTS'(1) << tag_head : '0;
            err_spurious_return <= err_spurious_return || (avl_rdata_valid && tag_empty);
        end
    end
endmodule
